// File: rtl/bht_predictor.sv
// Direct-mapped branch history table: 2-bit saturating counters plus targets, combinational
// lookup and mispredict detection, sequential update. Optional statistics under BHT_STATS_EN.
module bht_predictor #(
    parameter int PC_W = 12,
    parameter int IDX_W = 6,
    localparam int TAG_W = PC_W - 2 - IDX_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] if_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target,
    input  logic            upd_pred_taken,
    input  logic [PC_W-1:0] upd_pred_target,
    output logic            mispredict,
    output logic [PC_W-1:0] redirect_pc,
    output logic [31:0]     stat_lookups,
    output logic [31:0]     stat_mispred
);

    localparam int DEPTH = 1 << IDX_W;

    logic              valid_r  [DEPTH];
    logic [TAG_W-1:0]  tag_r    [DEPTH];
    logic [1:0]        cnt_r    [DEPTH];
    logic [PC_W-1:0]   target_r [DEPTH];

    logic [IDX_W-1:0]  if_idx_s;
    logic [TAG_W-1:0]  if_tag_s;
    logic              if_hit_s;
    logic [IDX_W-1:0]  upd_idx_s;
    logic [TAG_W-1:0]  upd_tag_s;
    logic              upd_hit_s;

    function automatic logic [1:0] cnt_inc(input logic [1:0] c);
        case (c)
            2'b00:   return 2'b01;
            2'b01:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b11;
            default: return 2'b11;
        endcase
    endfunction

    function automatic logic [1:0] cnt_dec(input logic [1:0] c);
        case (c)
            2'b00:   return 2'b00;
            2'b01:   return 2'b00;
            2'b10:   return 2'b01;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    // IF-stage lookup; reads the pre-update entry even when EXE writes the same index
    always_comb begin
        if_idx_s = if_pc[IDX_W+1:2];
        if_tag_s = if_pc[PC_W-1:IDX_W+2];
        if_hit_s = valid_r[if_idx_s] && (tag_r[if_idx_s] == if_tag_s);
        pred_hit = if_hit_s;
        pred_taken = if_hit_s & cnt_r[if_idx_s][1];
        if (pred_taken) begin
            pred_target = target_r[if_idx_s];
        end else begin
            pred_target = if_pc + PC_W'(4);
        end
    end

    // EXE-stage resolution: mispredict detection and redirect address
    always_comb begin
        upd_idx_s = upd_pc[IDX_W+1:2];
        upd_tag_s = upd_pc[PC_W-1:IDX_W+2];
        upd_hit_s = valid_r[upd_idx_s] && (tag_r[upd_idx_s] == upd_tag_s);
        mispredict = upd_valid & ((upd_taken != upd_pred_taken) |
                                  (upd_taken & (upd_target != upd_pred_target)));
        if (upd_taken) begin
            redirect_pc = upd_target;
        end else begin
            redirect_pc = upd_pc + PC_W'(4);
        end
    end

    // Valid bits: cleared by reset, set when a taken miss allocates
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_r[i] <= 1'b0;
            end
        end else if (upd_valid && !upd_hit_s && upd_taken) begin
            valid_r[upd_idx_s] <= 1'b1;
        end
    end

    // Entry payload; left unreset because an invalid entry's fields are never observed
    always_ff @(posedge clk) begin
        if (!rst && upd_valid) begin
            if (upd_hit_s) begin
                if (upd_taken) begin
                    cnt_r[upd_idx_s]    <= cnt_inc(cnt_r[upd_idx_s]);
                    target_r[upd_idx_s] <= upd_target;
                end else begin
                    cnt_r[upd_idx_s]    <= cnt_dec(cnt_r[upd_idx_s]);
                end
            end else if (upd_taken) begin
                tag_r[upd_idx_s]    <= upd_tag_s;
                cnt_r[upd_idx_s]    <= 2'b10;
                target_r[upd_idx_s] <= upd_target;
            end
        end
    end

`ifdef BHT_STATS_EN
    logic [31:0] lookups_r;
    logic [31:0] mispred_r;

    // Resolved-branch and mispredict counters, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            lookups_r <= 32'd0;
            mispred_r <= 32'd0;
        end else if (upd_valid) begin
            lookups_r <= lookups_r + 32'd1;
            if (mispredict) begin
                mispred_r <= mispred_r + 32'd1;
            end
        end
    end

    assign stat_lookups = lookups_r;
    assign stat_mispred = mispred_r;
`else
    assign stat_lookups = 32'd0;
    assign stat_mispred = 32'd0;
`endif

endmodule

// File: doc/bht_predictor.md
Name: bht_predictor

Overview:
- Parametrised dynamic branch predictor for the 5-stage pipeline; replaces the fixed "predict pc+4, flush on ctrl_clash" scheme.
- IF looks up a direct-mapped table of 2-bit saturating counters plus branch targets.
- EXE reports resolved outcome; block raises mispredict and supplies redirect PC.
- Table update is sequential; lookup and mispredict compare are combinational.

Parameters:
PC_W, 12, PC width in bits (byte address, word aligned)
IDX_W, 6, index bits; table depth = 2^IDX_W entries
TAG_W, PC_W-2-IDX_W, tag bits stored per entry (derived, not overridden)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
if_pc  in  PC_W  IF-stage PC for lookup
pred_hit  out  1  valid entry with matching tag
pred_taken  out  1  predicted taken (pred_hit & counter[1])
pred_target  out  PC_W  stored target if pred_taken, else if_pc+4
upd_valid  in  1  EXE holds a resolved branch/jump this cycle
upd_pc  in  PC_W  PC of that instruction
upd_taken  in  1  actual outcome
upd_target  in  PC_W  actual taken target
upd_pred_taken  in  1  prediction carried down the pipeline with the instruction
upd_pred_target  in  PC_W  predicted next PC carried down the pipeline
mispredict  out  1  flush IF/ID and ID/EXE, load redirect_pc
redirect_pc  out  PC_W  upd_taken ? upd_target : upd_pc+4
stat_lookups  out  32  resolved-branch count (optional feature)
stat_mispred  out  32  mispredict count (optional feature)

Behaviour:
- Entry fields: valid, tag[TAG_W], cnt[1:0], target[PC_W].
- Index = pc[IDX_W+1:2]; tag = pc[PC_W-1:IDX_W+2].
- Lookup (combinational): pred_hit = valid & tag match. pred_taken = pred_hit & cnt[1]. PC arithmetic is modulo 2^PC_W.
- mispredict = upd_valid & (upd_taken != upd_pred_taken | (upd_taken & upd_target != upd_pred_target)). It is 0 whenever upd_valid = 0.
- Update (clk edge, upd_valid=1, rst=0):
  - hit, taken: cnt saturating +1 (11 holds), target <= upd_target.
  - hit, not taken: cnt saturating -1 (00 holds), target unchanged.
  - miss, taken: allocate/overwrite entry with valid=1, new tag, cnt=10, target=upd_target.
  - miss, not taken: no change.
- Same-cycle lookup and update to the same index: lookup sees the pre-update entry (no bypass). The new value is visible next cycle.
- Reset: rst=1 clears every valid bit and both stat counters at the edge. Tags, counters and targets are don't-care. upd_valid in a rst cycle is ignored.
- After reset every lookup misses: pred_taken=0, pred_target=if_pc+4.
- Reset asserted mid-operation gives the same result; no partial updates survive.
- Combinational outputs are not registered. Pipeline freeze (halt/go) does not gate the table. The pipeline must hold upd_valid low while frozen.
- Latency: prediction 0 cycles; table update effective 1 cycle after the upd_valid edge.

Optional Feature:
BHT_STATS_EN defined:
- stat_lookups increments on every clk edge with upd_valid=1 & rst=0.
- stat_mispred increments when mispredict=1 on that edge.
- Both are 32-bit and wrap from 0xFFFF_FFFF to 0.

BHT_STATS_EN undefined:
- No counter registers.
- stat_lookups and stat_mispred are tied to 0.

Test Plan:
1. Reset, then if_pc=0x040 -> pred_hit=0, pred_taken=0, pred_target=0x044; stats=0.
2. upd_valid=1, upd_pc=0x040, upd_taken=1, upd_target=0x100, upd_pred_taken=0 -> mispredict=1, redirect_pc=0x100. Next cycle if_pc=0x040 -> pred_hit=1, pred_taken=1, pred_target=0x100.
3. From step 2, two not-taken updates at 0x040 with correct carried predictions:
   - First update (upd_pred_taken=1) -> mispredict=1, redirect_pc=0x044, cnt 10->01, pred_taken=0.
   - Second update (upd_pred_taken=0) -> mispredict=0, cnt 00.
   - A third taken update -> cnt 01, pred_taken still 0.
4. Alias: entry at 0x040, lookup 0x140 (same index 0x10, tag 1) -> miss, pred_target=0x144. Taken update 0x140->0x200 replaces the entry; lookup 0x040 then misses.
5. Same cycle: if_pc=0x040 with a taken update for 0x040 on an empty table -> pred_hit=0 that cycle, pred_hit=1 next cycle.
6. Populate 3 entries, assert rst for one cycle together with upd_valid=1 -> all lookups miss afterwards; with BHT_STATS_EN both stats read 0. Then 5 updates with 2 mispredicts -> stat_lookups=5, stat_mispred=2.
